mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multi-cycle successor to the single-cycle control unit, for the 24-bit CPU.
- A Moore/Mealy FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, so one shared memory and one ALU are reused.
- Handles a variable-latency memory through a MemReady handshake and traps illegal opcodes.
- Sits between the instruction register opcode field and the multi-cycle datapath mux and write-enable controls.

Parameters:
- OPCODE_W, 4, opcode field width. Must be ≥ 4; any set bit above bit 3 means the opcode is illegal.
- CNT_W, 32, width of the performance counters (used only with MC_PERF_CNT_EN).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  OPCODE_W  opcode field from the instruction register; valid from DECODE onward.
- MemReady  in  1  memory has completed the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, BranchNe  out  1 each  datapath controls.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- ALUSrcB  out  2  00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended offset.
- ALUOp  out  2  00 = add, 01 = sub, 10 = R-type funct, 11 = immediate op.
- InstrDone  out  1  one-cycle pulse in the final cycle of each instruction.
- Trap  out  1  sticky illegal-opcode flag.

Behaviour:
- Opcodes (package constants): 0 = R, 1 = ADDI, 2 = SUBI, 3 = SLTI, 4 = LW, 5 = SW, 6 = BEQ, 7 = BNE, 8 = J. Opcodes 9–15 are illegal.
- Reset (asynchronous): state = RST, opcode_q = 0, Trap = 0. Every output is 0 in RST.
- After reset is released, RST moves to FETCH on the next clock.
- Any output not listed for a state is 0.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00.
  - IRWrite = PCWrite = MemReady (Mealy).
  - Stay while MemReady = 0; go to DECODE when MemReady = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
  - Register Opcode into opcode_q.
  - Next state: R → EXEC_R; ADDI/SUBI/SLTI → EXEC_I; LW/SW → MEM_ADDR; BEQ/BNE → BRANCH; J → JUMP; illegal → TRAP.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next → WB_R.
- WB_R: RegDst = 1, MemToReg = 0, RegWrite = 1, InstrDone = 1. Next → FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11. Next → WB_I.
- WB_I: RegDst = 0, MemToReg = 0, RegWrite = 1, InstrDone = 1. Next → FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next → MEM_RD if opcode_q = LW, else MEM_WR.
- MEM_RD: MemRead = 1, IorD = 1. Hold while MemReady = 0; go to MEM_WB when MemReady = 1.
- MEM_WB: RegDst = 0, MemToReg = 1, RegWrite = 1, InstrDone = 1. Next → FETCH.
- MEM_WR: MemWrite = 1, IorD = 1. Hold while MemReady = 0. When MemReady = 1: InstrDone = 1, next → FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSrc = 01.
  - BranchNe = (opcode_q == BNE).
  - InstrDone = 1. Next → FETCH.
- JUMP: PCWrite = 1, PCSrc = 10, InstrDone = 1. Next → FETCH.
- TRAP: Trap = 1; all other outputs 0. Absorbing state; only Reset leaves it.
- Cycle counts with MemReady = 1 on every memory cycle:
  - R / I-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ / BNE / J: 3.
  - Each wait cycle adds 1.
- Memory-state outputs stay constant during a wait, because the memory requires stable requests.
- MemReady is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction or mid-wait: immediate return to RST. No write enable may glitch high, because outputs decode directly from the reset state register.
- Opcode changes after DECODE have no effect; only opcode_q is used from then on.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: adds outputs CycleCnt[CNT_W-1:0] and InstrCnt[CNT_W-1:0].
  - CycleCnt increments every clock when state ≠ RST and state ≠ TRAP.
  - InstrCnt increments on InstrDone.
  - Both reset asynchronously to 0 and wrap modulo 2^CNT_W.
- Undefined: no counter ports and no counter logic.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams (OP_R … OP_J);
  - the state encoding (RST, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP);
  - ALUOp, ALUSrcB and PCSrc encodings.
- One natural sub-module: mc_perf_counters, instantiated only under MC_PERF_CNT_EN.

Test Plan:
- Reset, then R-type (Opcode = 0), MemReady = 1 → states RST, FETCH, DECODE, EXEC_R, WB_R; RegWrite = 1 and RegDst = 1 in cycle 4; InstrDone pulses once.
- LW (Opcode = 4) with MemReady low for 3 cycles in MEM_RD → MemRead = 1 and IorD = 1 held for 4 cycles; MEM_WB has MemToReg = 1; total 8 cycles.
- BNE (Opcode = 7) → BRANCH with PCWriteCond = 1, BranchNe = 1, PCSrc = 01. BEQ (Opcode = 6) → BranchNe = 0.
- Opcode = 12 at DECODE → Trap = 1 from the next cycle; stays high for 20 cycles; all write enables 0; Reset clears it.
- Reset asserted during a MEM_WR wait → MemWrite drops to 0 asynchronously; FETCH follows 1 cycle after release.
- With MC_PERF_CNT_EN and CNT_W = 4: 5 J instructions (15 cycles) → InstrCnt = 5 and CycleCnt = 15; a further 2 cycles → CycleCnt wraps to 1.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM state encoding and datapath mux encodings
// shared by the multi-cycle control unit of the 24-bit CPU.
package mc_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUBI = 4'd2;
  localparam logic [3:0] OP_SLTI = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;

  typedef enum logic [3:0] {
    RST,
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    JUMP,
    TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFF = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/mc_perf_counters.sv
// mc_perf_counters: free-running cycle and retired-instruction
// counters, wrapping modulo 2^CNT_W.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cycle_en,
  input  logic             instr_en,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstrCnt
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      if (cycle_en) CycleCnt <= CycleCnt + 1'b1;
      if (instr_en) InstrCnt <= InstrCnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control FSM for the 24-bit CPU.
// Define MC_PERF_CNT_EN to add CycleCnt/InstrCnt perf counters.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic                BranchNe,
  output logic [1:0]          PCSrc,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                InstrDone,
  output logic                Trap
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    CycleCnt,
  output logic [CNT_W-1:0]    InstrCnt
`endif
);

  state_t     state;
  state_t     next;
  logic [3:0] opcode_q;
  logic       illegal;

  // Any set bit above bit 3 also lands above OP_J.
  assign illegal = Opcode > OPCODE_W'(OP_J);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= RST;
      opcode_q <= '0;
    end else begin
      state <= next;
      if (state == DECODE) opcode_q <= Opcode[3:0];
    end
  end

  always_comb begin
    next        = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    BranchNe    = 1'b0;
    PCSrc       = PC_ALU;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALU_ADD;
    InstrDone   = 1'b0;
    Trap        = 1'b0;
    unique case (state)
      RST: next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) next = DECODE;
      end
      DECODE: begin
        ALUSrcB = SRCB_OFF;
        if (illegal) begin
          next = TRAP;
        end else begin
          unique case (Opcode[3:0])
            OP_R:                      next = EXEC_R;
            OP_ADDI, OP_SUBI, OP_SLTI: next = EXEC_I;
            OP_LW, OP_SW:              next = MEM_ADDR;
            OP_BEQ, OP_BNE:            next = BRANCH;
            OP_J:                      next = JUMP;
            default:                   next = TRAP;
          endcase
        end
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        next    = WB_R;
      end
      WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        next      = FETCH;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_IMM;
        next    = WB_I;
      end
      WB_I: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        next      = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        next    = (opcode_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) next = MEM_WB;
      end
      MEM_WB: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        next      = FETCH;
      end
      MEM_WR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        if (MemReady) next = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = PC_OUT;
        BranchNe    = (opcode_q == OP_BNE);
        InstrDone   = 1'b1;
        next        = FETCH;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSrc     = PC_JMP;
        InstrDone = 1'b1;
        next      = FETCH;
      end
      TRAP: Trap = 1'b1;
      default: next = RST;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  mc_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .Clock    (Clock),
    .Reset    (Reset),
    .cycle_en ((state != RST) && (state != TRAP)),
    .instr_en (InstrDone),
    .CycleCnt (CycleCnt),
    .InstrCnt (InstrCnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
